sprite_motion_ctrl: RTL and testbench

//  Per-frame motion sequencer for the bouncing logo sprite. It owns the sprite position,

---
 rtl/sprite_motion_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
// Per-frame motion sequencer for the bouncing logo sprite. Owns the committed
// sprite position, direction flags and the collision counter that selects the
// background scene. One update is computed per accepted frame strobe and the
// results are published together so the pixel datapath never sees a half-move.
//
// Optional build macro: BOUNCE_FLASH_EN
//   When defined, adds output `flash`, held high for 8 frame strobes after a
//   bounce. When undefined, neither the port nor its counter exist.
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for frame_start; committed outputs stable
//   S_CALC_X | advance working x / dir_x, record x wall hit
//   S_CALC_Y | advance working y / dir_y, record y wall hit
//   S_COMMIT | publish working regs, pulse bounce, count collision

module sprite_motion_ctrl #(
    parameter int unsigned MAX_X   = 576,
    parameter int unsigned MAX_Y   = 448,
    parameter int unsigned START_X = 50,
    parameter int unsigned START_Y = 50,
    parameter int unsigned COLL_W  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       pause,
    input  logic [1:0] speed,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic [1:0] scene,
    output logic       bounce,
    output logic       busy
`ifdef BOUNCE_FLASH_EN
    ,
    output logic       flash
`endif
);

    localparam logic [9:0] MAX_X_L   = 10'(MAX_X);
    localparam logic [9:0] MAX_Y_L   = 10'(MAX_Y);
    localparam logic [9:0] START_X_L = 10'(START_X);
    localparam logic [9:0] START_Y_L = 10'(START_Y);
    localparam logic [COLL_W-1:0] COLL_ONE = {{(COLL_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC_X,
        S_CALC_Y,
        S_COMMIT
    } state_t;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
        logic       hit;
    } axis_t;

    state_t state;
    state_t state_nxt;

    logic              accept;
    logic              commit;
    logic [2:0]        step_q;
    logic [9:0]        work_x;
    logic [9:0]        work_y;
    logic              work_dx;
    logic              work_dy;
    logic              hit_x;
    logic              hit_y;
    logic [COLL_W-1:0] coll_cnt;
    axis_t             nxt_x;
    axis_t             nxt_y;

    // One axis move: step toward the wall, clamp onto it and reverse on contact.
    // Sums are 11 bits wide so a position near 1023 cannot wrap past the wall.
    function automatic axis_t axis_step(input logic [9:0] pos, input logic dir,
                                        input logic [2:0] step, input logic [9:0] lim);
        axis_t      r;
        logic [10:0] fwd;
        fwd   = {1'b0, pos} + {8'd0, step};
        r.pos = pos;
        r.dir = dir;
        r.hit = 1'b0;
        if (dir) begin
            if (fwd >= {1'b0, lim}) begin
                r.pos = lim;
                r.dir = 1'b0;
                r.hit = 1'b1;
            end else begin
                r.pos = fwd[9:0];
            end
        end else begin
            if ({1'b0, pos} <= {8'd0, step}) begin
                r.pos = 10'd0;
                r.dir = 1'b1;
                r.hit = 1'b1;
            end else begin
                r.pos = pos - {7'd0, step};
            end
        end
        return r;
    endfunction

    // Candidate axis results from the working registers.
    always_comb begin
        nxt_x = axis_step(work_x, work_dx, step_q, MAX_X_L);
        nxt_y = axis_step(work_y, work_dy, step_q, MAX_Y_L);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; frame_start is only looked at in IDLE,
    // so strobes arriving mid-update are dropped rather than queued.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (frame_start && !pause) begin
                    accept    = 1'b1;
                    state_nxt = S_CALC_X;
                end
            end
            S_CALC_X: state_nxt = S_CALC_Y;
            S_CALC_Y: state_nxt = S_COMMIT;
            S_COMMIT: begin
                commit    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Working registers: loaded on accept, then one axis per cycle. The step
    // is latched here so a speed change during the update has no effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q  <= 3'd1;
            work_x  <= START_X_L;
            work_y  <= START_Y_L;
            work_dx <= 1'b1;
            work_dy <= 1'b1;
            hit_x   <= 1'b0;
            hit_y   <= 1'b0;
        end else if (accept) begin
            step_q  <= {1'b0, speed} + 3'd1;
            work_x  <= sprite_x;
            work_y  <= sprite_y;
            work_dx <= dir_x;
            work_dy <= dir_y;
            hit_x   <= 1'b0;
            hit_y   <= 1'b0;
        end else if (state == S_CALC_X) begin
            work_x  <= nxt_x.pos;
            work_dx <= nxt_x.dir;
            hit_x   <= nxt_x.hit;
        end else if (state == S_CALC_Y) begin
            work_y  <= nxt_y.pos;
            work_dy <= nxt_y.dir;
            hit_y   <= nxt_y.hit;
        end
    end

    // Committed outputs: all fields change on the same edge leaving COMMIT;
    // bounce is high for exactly the first cycle the new position is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            sprite_x <= START_X_L;
            sprite_y <= START_Y_L;
            dir_x    <= 1'b1;
            dir_y    <= 1'b1;
            coll_cnt <= '0;
            bounce   <= 1'b0;
        end else begin
            bounce <= 1'b0;
            if (commit) begin
                sprite_x <= work_x;
                sprite_y <= work_y;
                dir_x    <= work_dx;
                dir_y    <= work_dy;
                bounce   <= hit_x | hit_y;
                if (hit_x | hit_y) begin
                    coll_cnt <= coll_cnt + COLL_ONE;
                end
            end
        end
    end

    assign scene = coll_cnt[1:0];

`ifdef BOUNCE_FLASH_EN
    logic [3:0] flash_cnt;

    // Flash timer: reload on a bounce commit, count down on every strobe seen
    // in IDLE (accepted or paused); strobes ignored while busy do not count.
    always_ff @(posedge clk) begin
        if (reset) begin
            flash_cnt <= 4'd0;
        end else if (commit && (hit_x | hit_y)) begin
            flash_cnt <= 4'd8;
        end else if ((state == S_IDLE) && frame_start && (flash_cnt != 4'd0)) begin
            flash_cnt <= flash_cnt - 4'd1;
        end
    end

    assign flash = (flash_cnt != 4'd0);
`endif

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Testbench for sprite_motion_ctrl. Three instances share clock, reset, pause
// and speed but have their own frame strobes:
//   a : default start (50,50)
//   r : start (575,20)  -- right-wall bounce
//   c : start (600,447) -- out-of-range x plus simultaneous corner hit
// Build with BOUNCE_FLASH_EN defined to also exercise the flash output.

module tb_sprite_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       pause;
    logic [1:0] speed;
    logic       fs_a, fs_r, fs_c;

    logic [9:0] x_a, y_a, x_r, y_r, x_c, y_c;
    logic       dx_a, dy_a, dx_r, dy_r, dx_c, dy_c;
    logic [1:0] sc_a, sc_r, sc_c;
    logic       b_a, b_r, b_c;
    logic       busy_a, busy_r, busy_c;
`ifdef BOUNCE_FLASH_EN
    logic       flash_a, flash_r, flash_c;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sprite_motion_ctrl dut_a (
        .clk(clk), .reset(reset), .frame_start(fs_a), .pause(pause), .speed(speed),
        .sprite_x(x_a), .sprite_y(y_a), .dir_x(dx_a), .dir_y(dy_a),
        .scene(sc_a), .bounce(b_a), .busy(busy_a)
`ifdef BOUNCE_FLASH_EN
        , .flash(flash_a)
`endif
    );

    sprite_motion_ctrl #(.START_X(575), .START_Y(20)) dut_r (
        .clk(clk), .reset(reset), .frame_start(fs_r), .pause(pause), .speed(speed),
        .sprite_x(x_r), .sprite_y(y_r), .dir_x(dx_r), .dir_y(dy_r),
        .scene(sc_r), .bounce(b_r), .busy(busy_r)
`ifdef BOUNCE_FLASH_EN
        , .flash(flash_r)
`endif
    );

    sprite_motion_ctrl #(.START_X(600), .START_Y(447)) dut_c (
        .clk(clk), .reset(reset), .frame_start(fs_c), .pause(pause), .speed(speed),
        .sprite_x(x_c), .sprite_y(y_c), .dir_x(dx_c), .dir_y(dy_c),
        .scene(sc_c), .bounce(b_c), .busy(busy_c)
`ifdef BOUNCE_FLASH_EN
        , .flash(flash_c)
`endif
    );

    typedef struct {
        int         which;
        int         n;
        logic [1:0] spd;
        logic       pz;
        int         ex_x;
        int         ex_y;
        logic       ex_dx;
        logic       ex_dy;
        int         ex_sc;
        logic       ex_b;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic set_fs(input int which, input logic v);
        case (which)
            0: fs_a = v;
            1: fs_r = v;
            default: fs_c = v;
        endcase
    endtask

    // One strobe then three more edges: the new values are visible right after.
    task automatic do_frame(input int which, input logic [1:0] spd, input logic pz);
        speed = spd;
        pause = pz;
        set_fs(which, 1'b1);
        tick();
        set_fs(which, 1'b0);
        repeat (3) tick();
        pause = 1'b0;
    endtask

    initial begin
        int         ox, oy, osc;
        logic       odx, ody, ob;

        //          which n spd   pz    x    y    dx    dy    sc b
        vecs[0]  = '{0, 1, 2'd1, 1'b0,  53,  53, 1'b1, 1'b1, 0, 1'b0};
        vecs[1]  = '{0, 1, 2'd3, 1'b0,  57,  57, 1'b1, 1'b1, 0, 1'b0};
        vecs[2]  = '{0, 1, 2'd3, 1'b1,  57,  57, 1'b1, 1'b1, 0, 1'b0};
        vecs[3]  = '{0, 1, 2'd2, 1'b0,  60,  60, 1'b1, 1'b1, 0, 1'b0};
        vecs[4]  = '{1, 1, 2'd3, 1'b0, 576,  24, 1'b0, 1'b1, 1, 1'b1};
        vecs[5]  = '{1, 1, 2'd3, 1'b0, 572,  28, 1'b0, 1'b1, 1, 1'b0};
        vecs[6]  = '{1, 1, 2'd0, 1'b0, 571,  29, 1'b0, 1'b1, 1, 1'b0};
        vecs[7]  = '{2, 1, 2'd0, 1'b0, 576, 448, 1'b0, 1'b0, 1, 1'b1};
        vecs[8]  = '{2, 1, 2'd3, 1'b0, 572, 444, 1'b0, 1'b0, 1, 1'b0};
        vecs[9]  = '{2, 111, 2'd3, 1'b0, 128, 0, 1'b0, 1'b1, 2, 1'b1};
        vecs[10] = '{2, 1, 2'd3, 1'b0, 124,   4, 1'b0, 1'b1, 2, 1'b0};

        reset = 1'b1; pause = 1'b0; speed = 2'd0;
        fs_a = 1'b0; fs_r = 1'b0; fs_c = 1'b0;

        // T1: reset values
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_x", 32'(x_a), 50);
        chk("rst_y", 32'(y_a), 50);
        chk("rst_dir", {30'd0, dx_a, dy_a}, 3);
        chk("rst_scene", 32'(sc_a), 0);
        chk("rst_bounce", 32'(b_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_x_r", 32'(x_r), 575);
        chk("rst_x_c", 32'(x_c), 600);
`ifdef BOUNCE_FLASH_EN
        chk("rst_flash", 32'(flash_a), 0);
`endif

        // T2: single step at speed 0 with latency/busy profile
        speed = 2'd0;
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        chk("t2_busy1", 32'(busy_a), 1);
        tick();
        chk("t2_busy2", 32'(busy_a), 1);
        tick();
        chk("t2_busy3", 32'(busy_a), 1);
        chk("t2_x_hold", 32'(x_a), 50);
        tick();
        chk("t2_busy_end", 32'(busy_a), 0);
        chk("t2_x", 32'(x_a), 51);
        chk("t2_y", 32'(y_a), 51);
        chk("t2_bounce", 32'(b_a), 0);

        // Table: main function, walls, corner, out-of-range start, wrap-free edges
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                do_frame(vecs[i].which, vecs[i].spd, vecs[i].pz);
            end
            case (vecs[i].which)
                0: begin ox = 32'(x_a); oy = 32'(y_a); odx = dx_a; ody = dy_a; osc = 32'(sc_a); ob = b_a; end
                1: begin ox = 32'(x_r); oy = 32'(y_r); odx = dx_r; ody = dy_r; osc = 32'(sc_r); ob = b_r; end
                default: begin ox = 32'(x_c); oy = 32'(y_c); odx = dx_c; ody = dy_c; osc = 32'(sc_c); ob = b_c; end
            endcase
            chk($sformatf("v%0d_x", i), ox, vecs[i].ex_x);
            chk($sformatf("v%0d_y", i), oy, vecs[i].ex_y);
            chk($sformatf("v%0d_dx", i), 32'(odx), 32'(vecs[i].ex_dx));
            chk($sformatf("v%0d_dy", i), 32'(ody), 32'(vecs[i].ex_dy));
            chk($sformatf("v%0d_scene", i), osc, vecs[i].ex_sc);
            chk($sformatf("v%0d_bounce", i), 32'(ob), 32'(vecs[i].ex_b));
        end
        tick();
        chk("bounce_one_cycle", 32'(b_c), 0);

`ifdef BOUNCE_FLASH_EN
        // dut_r bounced at v4 (load 8), then two accepted frames -> 6 left
        for (int k = 0; k < 5; k++) do_frame(1, 2'd0, 1'b1);
        chk("flash_still_on", 32'(flash_r), 1);
        do_frame(1, 2'd0, 1'b1);
        chk("flash_off", 32'(flash_r), 0);
        chk("flash_pause_x", 32'(x_r), 571);
`endif

        // T5: overlapping strobe and mid-update speed change on dut_a (at 60,60)
        speed = 2'd0;
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        speed = 2'd3;
        tick();
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        tick();
        chk("t5_x", 32'(x_a), 61);
        chk("t5_y", 32'(y_a), 61);
        chk("t5_busy", 32'(busy_a), 0);
        repeat (4) tick();
        chk("t5_no_second_x", 32'(x_a), 61);
        chk("t5_no_second_busy", 32'(busy_a), 0);
        pause = 1'b1;
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        pause = 1'b0;
        chk("t5_pause_busy", 32'(busy_a), 0);
        chk("t5_pause_x", 32'(x_a), 61);

        // T6: reset asserted while in CALC_X
        speed = 2'd3;
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        chk("t6_busy_pre", 32'(busy_a), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_busy", 32'(busy_a), 0);
        chk("t6_x", 32'(x_a), 50);
        chk("t6_y", 32'(y_a), 50);
        chk("t6_bounce", 32'(b_a), 0);
        chk("t6_scene_c", 32'(sc_c), 0);
        chk("t6_x_r", 32'(x_r), 575);
        tick();
        chk("t6_no_bounce", 32'(b_a), 0);
        chk("t6_x_hold", 32'(x_a), 50);
        do_frame(0, 2'd0, 1'b0);
        chk("t6_after_x", 32'(x_a), 51);
        chk("t6_after_y", 32'(y_a), 51);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
